// File: rtl/wbs_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbs_decoder_pkg
// Description : Shared types and constants for the Wishbone slave decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package wbs_decoder_pkg;

    // Decoder transaction state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Read data handed back to the master on any error response
    localparam logic [31:0] C_ERR_DATA = 32'hDEAD_BEEF;

    // Width of the slave wait counter; covers TIMEOUT up to 65535
    localparam int unsigned C_WDOG_W = 16;

endpackage : wbs_decoder_pkg
`default_nettype wire

// File: rtl/wbs_decoder_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wbs_watchdog
// Description : Counts cycles spent waiting for a slave acknowledge and flags
//               when the wait has lasted TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wbs_watchdog
    import wbs_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Expiry fires during the TIMEOUT-th enabled cycle, so the count at
    // that point is TIMEOUT-1.
    localparam logic [C_WDOG_W-1:0] C_LIMIT = C_WDOG_W'(TIMEOUT - 1);

    logic [C_WDOG_W-1:0] r_cnt;

    // Wait counter: cleared on a new access, advances every waiting cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + C_WDOG_W'(1);
        end
    end

    assign expired = enable && (r_cnt == C_LIMIT);

endmodule : wbs_watchdog
`default_nettype wire

// File: rtl/wbs_decoder.sv
`default_nettype none
// ============================================================================
// Module      : wbs_decoder
// Description : Wishbone management-port address decoder. Routes a single
//               access to one of NSLV slave channels, waits for its ack with
//               a watchdog, and returns ERR_DATA on a decode miss or timeout
//               while latching a sticky error flag and first-error address.
// Revision    : 1.0 - initial release
// ============================================================================
module wbs_decoder
    import wbs_decoder_pkg::*;
#(
    parameter int unsigned          NSLV     = 4,
    parameter logic [NSLV*32-1:0]   BASE     = {32'h3003_0000, 32'h3002_0000,
                                                32'h3001_0000, 32'h3000_0000},
    parameter logic [NSLV*32-1:0]   MASK     = {4{32'hFFFF_0000}},
    parameter int unsigned          TIMEOUT  = 255,
    parameter logic [31:0]          ERR_DATA = C_ERR_DATA
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    // Management-side Wishbone
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    // Downstream slave channels
    output logic [NSLV-1:0]      sl_stb_o,
    output logic                 sl_cyc_o,
    output logic                 sl_we_o,
    output logic [3:0]           sl_sel_o,
    output logic [31:0]          sl_adr_o,
    output logic [31:0]          sl_dat_o,
    input  logic [NSLV*32-1:0]   sl_dat_i,
    input  logic [NSLV-1:0]      sl_ack_i,
    // Error reporting
    output logic                 err_irq_o,
    output logic [31:0]          err_adr_o,
    input  logic                 err_clr_i
);

    state_t             r_state;
    logic [NSLV-1:0]    r_sel;
    logic [NSLV-1:0]    r_stb;
    logic               r_cyc;
    logic               r_we;
    logic [3:0]         r_sel_b;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;
    logic               r_ack;
    logic [31:0]        r_rdat;
    logic               r_err_irq;
    logic [31:0]        r_err_adr;

    logic [NSLV-1:0]    w_hit;
    logic [NSLV-1:0]    w_first;
    logic               w_any_hit;
    logic               w_req;
    logic               w_start;
    logic               w_sel_ack;
    logic [31:0]        w_sel_dat;
    logic               w_expired;
    logic               w_err_miss;
    logic               w_err_tout;
    logic               w_err;
    logic [31:0]        w_err_adr;

    // Per-channel address match
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_hit
            assign w_hit[gi] = ((wbs_adr_i & MASK[gi*32 +: 32]) ==
                                (BASE[gi*32 +: 32] & MASK[gi*32 +: 32]));
        end
    endgenerate

    // Isolate the lowest set bit so overlapping regions favour channel 0
    assign w_first   = w_hit & (~w_hit + NSLV'(1));
    assign w_any_hit = |w_hit;

    assign w_req   = wbs_cyc_i && wbs_stb_i && !r_ack;
    assign w_start = (r_state == ST_IDLE) && w_req && w_any_hit;

    // Only the channel currently being served may complete the access
    assign w_sel_ack = |(sl_ack_i & r_sel);

    // Read-data mux for the served channel
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_sel_dat = w_sel_dat | ({32{r_sel[i]}} & sl_dat_i[i*32 +: 32]);
        end
    end

    wbs_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (w_start),
        .enable  (r_state == ST_ACTIVE),
        .expired (w_expired)
    );

    // A coincident ack beats expiry, and a dropped cycle is a silent abort
    assign w_err_miss = (r_state == ST_IDLE) && w_req && !w_any_hit;
    assign w_err_tout = (r_state == ST_ACTIVE) && wbs_cyc_i && !w_sel_ack && w_expired;
    assign w_err      = w_err_miss || w_err_tout;
    assign w_err_adr  = w_err_miss ? wbs_adr_i : r_adr;

    // Transaction FSM with registered slave and master-side outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_stb   <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel_b <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_rdat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack  <= 1'b0;
                    r_rdat <= '0;
                    if (w_req) begin
                        r_adr   <= wbs_adr_i;
                        r_dat   <= wbs_dat_i;
                        r_sel_b <= wbs_sel_i;
                        r_we    <= wbs_we_i;
                        if (w_any_hit) begin
                            r_sel   <= w_first;
                            r_stb   <= w_first;
                            r_cyc   <= 1'b1;
                            r_state <= ST_ACTIVE;
                        end else begin
                            // Decode miss: no slave sees it, write data is dropped
                            r_sel   <= '0;
                            r_ack   <= 1'b1;
                            r_rdat  <= ERR_DATA;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!wbs_cyc_i) begin
                        r_stb   <= '0;
                        r_cyc   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_sel_ack) begin
                        r_stb   <= '0;
                        r_cyc   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_rdat  <= w_sel_dat;
                        r_state <= ST_RESP;
                    end else if (w_expired) begin
                        r_stb   <= '0;
                        r_cyc   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_rdat  <= ERR_DATA;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_rdat  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_stb   <= '0;
                    r_cyc   <= 1'b0;
                    r_ack   <= 1'b0;
                    r_rdat  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flag; the address is only loaded by the first error,
    // unless a clear arrives together with the new error
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_err_irq <= 1'b0;
            r_err_adr <= '0;
        end else if (w_err) begin
            r_err_irq <= 1'b1;
            if (!r_err_irq || err_clr_i) begin
                r_err_adr <= w_err_adr;
            end
        end else if (err_clr_i) begin
            r_err_irq <= 1'b0;
            r_err_adr <= '0;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdat;
    assign sl_stb_o  = r_stb;
    assign sl_cyc_o  = r_cyc;
    assign sl_we_o   = r_we;
    assign sl_sel_o  = r_sel_b;
    assign sl_adr_o  = r_adr;
    assign sl_dat_o  = r_dat;
    assign err_irq_o = r_err_irq;
    assign err_adr_o = r_err_adr;

endmodule : wbs_decoder
`default_nettype wire
